// File: rtl/mul_seq_ctrl.sv
// Sequencer for the repeated-addition multiplier: takes A then B over a
// valid/ready stream, steps the datapath until B hits zero, then reports the product.
module mul_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_valid_i,
  input  logic [WIDTH-1:0] op_data_i,
  output logic             op_ready_o,
  output logic [WIDTH-1:0] data_out_o,
  output logic             ldA_o,
  output logic             ldB_o,
  output logic             ldP_o,
  output logic             clrP_o,
  output logic             decB_o,
  input  logic             eqZ_i,
  input  logic [WIDTH-1:0] prod_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] iter_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_GET_A, S_GET_B, S_ADD, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic             ovf_int_q, ovf_int_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] iter_cnt_q, iter_cnt_d;

  logic             xfer;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  // Mirror of the datapath adder: a wrapped sum smaller than an addend means carry-out.
  assign add_sum   = prod_in_i + a_q;
  assign add_carry = add_sum < a_q;

  assign op_ready_o = (state_q == S_GET_A) || (state_q == S_GET_B);
  assign xfer       = op_valid_i && op_ready_o;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign result_o   = result_q;
  assign ovf_o      = ovf_q;
  assign iter_cnt_o = iter_cnt_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    iter_d     = iter_q;
    ovf_int_d  = ovf_int_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    iter_cnt_d = iter_cnt_q;
    data_out_o = '0;
    ldA_o      = 1'b0;
    ldB_o      = 1'b0;
    ldP_o      = 1'b0;
    clrP_o     = 1'b0;
    decB_o     = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_GET_A;
      S_GET_A: if (xfer) begin
        data_out_o = op_data_i;
        ldA_o      = 1'b1;
        a_d        = op_data_i;
        state_d    = S_GET_B;
      end
      S_GET_B: if (xfer) begin
        data_out_o = op_data_i;
        ldB_o      = 1'b1;
        clrP_o     = 1'b1;
        iter_d     = '0;
        ovf_int_d  = 1'b0;
        state_d    = S_ADD;
      end
      S_ADD: if (eqZ_i) begin
        result_d   = prod_in_i;
        ovf_d      = ovf_int_q;
        iter_cnt_d = iter_q;
        state_d    = S_DONE;
      end else begin
        ldP_o     = 1'b1;
        decB_o    = 1'b1;
        iter_d    = iter_q + WIDTH'(1);
        ovf_int_d = ovf_int_q | add_carry;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      iter_q     <= '0;
      ovf_int_q  <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      iter_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      iter_q     <= iter_d;
      ovf_int_q  <= ovf_int_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      iter_cnt_q <= iter_cnt_d;
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a cycle-schedule model of each job checks every output
// every cycle; a behavioural datapath closes the eqZ/prod_in loop.
module tb_mul_seq_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, op_valid = 1'b0;
  logic [W-1:0] op_data = '0;
  logic         op_ready, ldA, ldB, ldP, clrP, decB, eqZ, busy, done, ovf;
  logic [W-1:0] data_out, prod_in, result, iter_cnt;
  logic [W-1:0] dp_a = '0, dp_b = '0, dp_p = '0;

  mul_seq_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_valid_i(op_valid),
    .op_data_i(op_data), .op_ready_o(op_ready), .data_out_o(data_out),
    .ldA_o(ldA), .ldB_o(ldB), .ldP_o(ldP), .clrP_o(clrP), .decB_o(decB),
    .eqZ_i(eqZ), .prod_in_i(prod_in), .busy_o(busy), .done_o(done),
    .result_o(result), .ovf_o(ovf), .iter_cnt_o(iter_cnt)
  );

  always #5 clk = ~clk;

  // Datapath: A/B/P registers driven by the strobes.
  always @(posedge clk) begin
    if (ldA) dp_a <= data_out;
    if (ldB) dp_b <= data_out;
    else if (decB) dp_b <= dp_b - 16'd1;
    if (clrP) dp_p <= '0;
    else if (ldP) dp_p <= dp_p + dp_a;
  end
  assign eqZ     = (dp_b == '0);
  assign prod_in = dp_p;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0, nerr = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Current job, described by its operands and stall counts.
  bit     j_on = 0;
  int     j_c0 = 0, j_sa = 0, j_sb = 0, seen_done = -1;
  longint j_a = 0, j_b = 0;
  longint h_res = 0, h_ovf = 0, h_iter = 0;
  bit     rst_pend = 0;

  always @(negedge clk) begin
    int rel, base;
    bit e_ldA, e_ldB, e_ldP, e_done, e_busy, e_rdy;
    longint e_data;
    if (rst) rst_pend = 1;
    else begin
      if (rst_pend) begin
        j_on = 0; h_res = 0; h_ovf = 0; h_iter = 0; rst_pend = 0;
      end
      rel    = j_on ? cyc - j_c0 : -100;
      base   = 3 + j_sa + j_sb;
      e_ldA  = (rel == 1 + j_sa);
      e_ldB  = (rel == 2 + j_sa + j_sb);
      e_ldP  = (rel >= base) && (rel < base + j_b);
      e_done = (rel == base + j_b + 1);
      e_busy = (rel >= 1) && (rel <= base + j_b + 1);
      e_rdy  = (rel >= 1) && (rel <= 2 + j_sa + j_sb);
      e_data = e_ldA ? j_a : (e_ldB ? j_b : 0);
      if (e_done) begin
        h_res  = (j_a * j_b) % 65536;
        h_ovf  = (j_a * j_b > 65535) ? 1 : 0;
        h_iter = j_b;
      end
      if (done && j_on) seen_done = rel;
      chk("op_ready", op_ready, e_rdy);
      chk("data_out", data_out, e_data);
      chk("ldA", ldA, e_ldA);
      chk("ldB", ldB, e_ldB);
      chk("clrP", clrP, e_ldB);
      chk("ldP", ldP, e_ldP);
      chk("decB", decB, e_ldP);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("result", result, h_res);
      chk("ovf", ovf, h_ovf);
      chk("iter_cnt", iter_cnt, h_iter);
    end
  end

  // gl: extra start pulses while busy and in DONE; rst_at: relative cycle to reset (-1 none).
  task automatic run_job(input int a, input int b, input int sa, input int sb,
                         input bit gl, input int rst_at, input int x_done,
                         input int x_res, input int x_ovf, input int x_iter);
    int base, last;
    base = 3 + sa + sb;
    last = (rst_at >= 0) ? rst_at + 1 : base + b + 2;
    @(posedge clk); #1;
    j_a = a; j_b = b; j_sa = sa; j_sb = sb; j_c0 = cyc; j_on = 1; seen_done = -1;
    for (int r = 0; r <= last; r++) begin
      if (r > 0) begin @(posedge clk); #1; end
      start = (r == 0) || (gl && (r == 1 || r == base + 2 || r == base + b + 1));
      rst   = (r == rst_at);
      if (r == 1 + sa) begin op_valid = 1; op_data = W'(a); end
      else if (r == 2 + sa + sb) begin op_valid = 1; op_data = W'(b); end
      else if (r == 0 || r >= base) begin op_valid = 1; op_data = 16'hBEEF ^ W'(r); end
      else begin op_valid = 0; op_data = 16'h5A5A ^ W'(r); end
    end
    start = 0; op_valid = 0;
    @(negedge clk); #1;
    if (rst_at < 0) chk("done_cycle", seen_done, x_done);
    chk("lit_result", result, x_res);
    chk("lit_ovf", ovf, x_ovf);
    chk("lit_iter", iter_cnt, x_iter);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    //       A    B    sa sb gl rst  done  result ovf iter
    run_job(3,   5,   0, 0, 0, -1,  9,    15,    0, 5);
    run_job(7,   0,   0, 0, 0, -1,  4,    0,     0, 0);
    run_job(0,   4,   0, 0, 0, -1,  8,    0,     0, 4);
    run_job(300, 300, 0, 0, 0, -1,  304,  24464, 1, 300);
    run_job(2,   2,   0, 0, 0, -1,  6,    4,     0, 2);
    run_job(4,   6,   3, 2, 1, -1,  15,   24,    0, 6);
    run_job(5,   10,  0, 0, 0, 6,   0,    0,     0, 0);
    run_job(2,   3,   0, 0, 0, -1,  7,    6,     0, 3);
    run_job(256, 256, 0, 0, 0, -1,  260,  0,     1, 256);
    run_job(255, 257, 0, 0, 0, -1,  261,  65535, 0, 257);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
